ysyx_22050368_div: RTL and testbench

- Iterative radix-2 integer divider for the RV64 core's M-extension (DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW).
- Sits beside the single-cycle integer ALU in the execute stage and takes the same 64-bit op1/op2 operands.
- Decoupled valid/ready handshakes on both sides; always returns quotient and remainder together.
- Multi-cycle; supports flush from the pipeline.

---
 rtl/ysyx_22050368_div.sv | 131 +++++++++++++
 tb/tb_ysyx_22050368_div.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22050368_div.sv
// Iterative radix-2 restoring divider for RV64M: DIV/DIVU/REM/REMU and their W forms.
// The unit takes one request at a time and returns quotient and remainder together.
module ysyx_22050368_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] part;
  logic [XLEN-1:0] dsr;
  logic [5:0]      cnt;
  logic            q_neg, r_neg, word_r;

  logic            accept;
  logic [XLEN-1:0] a_ext, b_ext, a_sx, a_abs, b_abs;
  logic            a_neg, b_neg, b_zero, ovf;

  // Operands in the selected width; a_sx is the sign-extended dividend used by special results.
  always_comb begin
    a_sx  = div_word ? {{32{op1[31]}}, op1[31:0]} : op1;
    a_ext = (div_word && !div_signed) ? {32'b0, op1[31:0]} : a_sx;
    b_ext = div_word ? (div_signed ? {{32{op2[31]}}, op2[31:0]} : {32'b0, op2[31:0]}) : op2;
    a_neg = div_signed & a_ext[XLEN-1];
    b_neg = div_signed & b_ext[XLEN-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf   = div_signed && (b_ext == '1) &&
            (div_word ? (a_ext == 64'hFFFF_FFFF_8000_0000) : (a_ext == 64'h8000_0000_0000_0000));
  end

  // One restoring step: no borrow out of the 65-bit subtract means partial >= divisor.
  logic [XLEN:0]   shl, diff;
  logic            ge;
  always_comb begin
    shl  = {part, dvd_q[XLEN-1]};
    diff = shl - {1'b0, dsr};
    ge   = ~diff[XLEN];
  end

  logic [XLEN-1:0] q_raw, r_raw, q_fix, r_fix;
  always_comb begin
    q_raw = word_r ? {32'b0, dvd_q[31:0]} : dvd_q;
    r_raw = word_r ? {32'b0, part[31:0]}  : part;
    q_raw = q_neg ? -q_raw : q_raw;
    r_raw = r_neg ? -r_raw : r_raw;
    q_fix = word_r ? {{32{q_raw[31]}}, q_raw[31:0]} : q_raw;
    r_fix = word_r ? {{32{r_raw[31]}}, r_raw[31:0]} : r_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) & rst_n & ~flush;
    out_valid = (state == DONE);
    accept    = in_valid & in_ready;
    case (state)
      IDLE: if (accept) state_nxt = (b_zero | ovf) ? DONE : CALC;
      CALC: if (cnt == 6'd0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      part      <= '0;
      dsr       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      word_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          // Word operands are left-aligned so the same MSB-first shift serves both widths.
          dvd_q  <= div_word ? {a_abs[31:0], 32'b0} : a_abs;
          dsr    <= div_word ? {32'b0, b_abs[31:0]} : b_abs;
          part   <= '0;
          cnt    <= div_word ? 6'd31 : 6'd63;
          q_neg  <= a_neg ^ b_neg;
          r_neg  <= a_neg;
          word_r <= div_word;
          if (b_zero) begin
            quotient  <= '1;
            remainder <= a_sx;
          end else if (ovf) begin
            quotient  <= a_sx;
            remainder <= '0;
          end
        end
        CALC: begin
          part  <= ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
          dvd_q <= {dvd_q[XLEN-2:0], ge};
          cnt   <= cnt - 6'd1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050368_div.sv
// Directed self-checking bench for the RV64M iterative divider.
module tb_ysyx_22050368_div;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, div_signed, div_word, flush, out_valid, out_ready;
  logic [63:0] op1, op2, quotient, remainder;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [63:0] q_hold, r_hold;

  ysyx_22050368_div #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .div_signed(div_signed), .div_word(div_word),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; the following rising edge is the accept edge T.
  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    @(negedge clk);
    op1 = a; op2 = b; div_signed = s; div_word = w; in_valid = 1'b1;
    #1 chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1 = 64'hDEAD_BEEF_DEAD_BEEF; op2 = 64'h1; div_signed = ~s; div_word = ~w;
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_done(input string tag, input int exp_lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic s, input logic w, input int exp_lat,
                     input logic [63:0] eq, input logic [63:0] er);
    start(a, b, s, w);
    wait_done({tag, "_lat"}, exp_lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    @(posedge clk); #1;
    chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; div_signed = 1'b0; div_word = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    run("divu",      64'd100, 64'd7, 1'b0, 1'b0, 66, 64'd14, 64'd2);
    run("div_neg",   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 66,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divu_big",  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 66,
        64'h0FFF_FFFF_FFFF_FFFF, 64'hF);
    run("div_minby2", 64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0, 66,
        64'hC000_0000_0000_0000, 64'd0);
    run("divu_zero", 64'd5, 64'd0, 1'b0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    run("div_ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,
        64'h8000_0000_0000_0000, 64'd0);
    run("divuw",     64'h0000_0000_8000_0000, 64'd1, 1'b0, 1'b1, 34,
        64'hFFFF_FFFF_8000_0000, 64'd0);
    run("remw",      64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b1, 1'b1, 34,
        64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divw_ovf",  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1,
        64'hFFFF_FFFF_8000_0000, 64'd0);
    run("divuw_zero", 64'h0000_0000_8000_0001, 64'h1234_5678_0000_0000, 1'b0, 1'b1, 1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    start(64'd1000, 64'd10, 1'b0, 1'b0);
    wait_done("bp_lat", 66);
    q_hold = quotient; r_hold = remainder;
    chk("bp_q", quotient, 64'd100);
    chk("bp_r", remainder, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_q", quotient, q_hold);
      chk("bp_hold_r", remainder, r_hold);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Flush in cycle T+20 of a 64-bit op: back in IDLE at T+21, no result ever.
    start(64'd12345, 64'd3, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd1);
    lat = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("flush_no_result", 64'(lat), 64'd0);

    // Flush with in_valid in IDLE: the divide-by-zero request must not be accepted.
    @(negedge clk);
    op1 = 64'd9; op2 = 64'd0; div_signed = 1'b0; div_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept_valid", 64'(out_valid), 64'd0);
    #1 chk("flush_no_accept_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of CALC clears everything.
    start(64'd777, 64'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_calc_valid", 64'(out_valid), 64'd0);
    chk("rst_calc_in_ready", 64'(in_ready), 64'd0);
    chk("rst_calc_q", quotient, 64'd0);
    chk("rst_calc_r", remainder, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_calc_idle", 64'(in_ready), 64'd1);
    run("after_rst", 64'd50, 64'd6, 1'b0, 1'b0, 66, 64'd8, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
